nz_count_monitor: RTL and testbench
===================================

Name: nz_count_monitor

Overview:
- Upstream neighbour of the linear-rate calculator: observes one layer's output-activation stream and counts non-zero elements.
- Produces the `num_nonzeros` / `shape` pair that the calculator divides to get measured sparsity.
- One layer per transaction: the layer is armed with its output count, beats are counted, then one result is presented and held until it is consumed.

Parameters:
- DATA_WIDTH, 16, bit width of one activation element.
- LANES, 4, activation elements per stream beat (power of two, 1..16).
- CNT_WIDTH, 16, width of the shape and non-zero counters (matches the calculator's 16-bit inputs).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- layer_vld  in  1  arm request for a new layer.
- layer_shape  in  CNT_WIDTH  number of output elements in the layer (num_out).
- layer_rdy  out  1  high only in IDLE.
- act_vld  in  1  activation beat valid.
- act_dat  in  LANES*DATA_WIDTH  packed elements; lane 0 = bits [DATA_WIDTH-1:0].
- act_rdy  out  1  high only in COUNT.
- nz_vld  out  1  result valid; drives the calculator's shape_vld.
- nz_dat  out  CNT_WIDTH  non-zero count; drives num_nonzeros.
- shape_dat  out  CNT_WIDTH  latched layer_shape; drives shape_dat.
- nz_rdy  in  1  result consumed (tie to 1 when the consumer is always ready).
- overflow  out  1  sticky flag, set when the non-zero count saturates in the current layer.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state = IDLE; layer_rdy = 1; act_rdy = 0; nz_vld = 0; nz_dat = 0; shape_dat = 0; overflow = 0; internal remaining/accumulator = 0.
- Reset mid-layer: aborts without emitting a result, and any partial count is discarded.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - On layer_vld & layer_rdy: latch shape_dat <= layer_shape, remaining <= layer_shape, acc <= 0, overflow <= 0.
  - If layer_shape == 0, go directly to DONE (result 0/0); otherwise go to COUNT.
- COUNT:
  - Each act_vld & act_rdy beat: valid lanes = min(LANES, remaining), lowest lanes first. Lanes at or above `remaining` are masked and not counted.
  - A lane is non-zero when any bit of its element is set.
  - acc <= sat(acc + popcount(masked non-zero mask)), saturating at 2^CNT_WIDTH-1; saturation sets overflow.
  - remaining <= remaining - valid lanes.
  - When that result reaches 0, go to DONE on the same edge.
- DONE:
  - nz_vld = 1, nz_dat = acc; shape_dat is stable.
  - Hold until nz_vld & nz_rdy, then go to IDLE.
  - layer_rdy and act_rdy are 0, so no back-to-back overlap.
- Latency: the final beat accepted at edge N gives nz_vld high after edge N; the earliest new layer arm is the edge after consumption.
- Ignored inputs: layer_vld in COUNT/DONE is ignored (rdy low); act_vld in IDLE/DONE is ignored.
- Simultaneous events: reset has priority over every handshake in the same cycle.
- Width rule: popcount width is clog2(LANES+1); it is zero-extended before the add, and the sum is computed at CNT_WIDTH+1 bits, then saturated.

Decomposition:
- Shared package (sched_pkg): state enum nz_state_t {IDLE, COUNT, DONE}; constants CNT_WIDTH_DEFAULT = 16 and LANES_DEFAULT = 4, shared with the linear-rate calculator and the scheduler.
- One sub-module, nz_lane_popcount: combinational. Takes act_dat and the valid-lane count, and returns the masked non-zero count. Parameterised by LANES and DATA_WIDTH.

Test Plan:
- Full beats: shape=8, LANES=4; beats {0,5,0,7}, {1,2,3,0} -> nz_dat=5, shape_dat=8, nz_vld one cycle after the 2nd beat.
- Partial last beat: shape=6; beats {1,1,1,1}, {1,1,9,9} -> nz_dat=6; lanes 2-3 of beat 2 are masked.
- Zero shape: shape=0 -> DONE without any act_rdy; nz_dat=0, shape_dat=0.
- Backpressure: nz_rdy=0 for 5 cycles -> nz_vld and nz_dat hold, layer_rdy=0, act_rdy=0; the next arm is accepted the cycle after nz_rdy=1.
- Saturation: CNT_WIDTH=4, shape=15, 4 beats of all-ones -> nz_dat=15. Counting the 15 valid lanes exactly reaches 15; no saturation occurs, overflow=0.
- Reset mid-layer: shape=8, 1 beat accepted, reset pulsed -> IDLE, nz_vld never asserted, shape_dat=0. A new layer then counts from 0.

Source files
------------

// File: rtl/sched_pkg.sv
// Types and defaults shared by the non-zero monitor, the linear-rate calculator
// and the scheduler.
package sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } nz_state_t;

  localparam int CNT_WIDTH_DEFAULT = 16;
  localparam int LANES_DEFAULT     = 4;

endpackage

// File: rtl/nz_lane_popcount.sv
// Counts the non-zero elements among the lowest `lanes` lanes of one beat.
module nz_lane_popcount #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic [LANES*DATA_WIDTH-1:0] act_dat,
  input  logic [$clog2(LANES+1)-1:0]  lanes,
  output logic [$clog2(LANES+1)-1:0]  count
);

  localparam int PW = $clog2(LANES + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((PW'(i) < lanes) && (|act_dat[i*DATA_WIDTH +: DATA_WIDTH])) begin
        count = count + PW'(1);
      end
    end
  end

endmodule

// File: rtl/nz_count_monitor.sv
// Counts non-zero activations of one layer and presents the num_nonzeros/shape
// pair until the consumer takes it.
module nz_count_monitor
  import sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = LANES_DEFAULT,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        layer_vld,
  input  logic [CNT_WIDTH-1:0]        layer_shape,
  output logic                        layer_rdy,
  input  logic                        act_vld,
  input  logic [LANES*DATA_WIDTH-1:0] act_dat,
  output logic                        act_rdy,
  output logic                        nz_vld,
  output logic [CNT_WIDTH-1:0]        nz_dat,
  output logic [CNT_WIDTH-1:0]        shape_dat,
  input  logic                        nz_rdy,
  output logic                        overflow
);

  localparam int PW = $clog2(LANES + 1);

  nz_state_t            state;
  logic [CNT_WIDTH-1:0] remaining;
  logic [CNT_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] shape_q;
  logic                 ovf_q;
  logic [PW-1:0]        lanes;
  logic [PW-1:0]        pop;
  logic [CNT_WIDTH:0]   sat_sum;
  logic [CNT_WIDTH-1:0] rem_next;

  // Returns {saturated, value}; the add is done one bit wider to catch the carry.
  function automatic logic [CNT_WIDTH:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                 input logic [PW-1:0]        p);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + {{(CNT_WIDTH+1-PW){1'b0}}, p};
    if (sum[CNT_WIDTH]) begin
      return {1'b1, {CNT_WIDTH{1'b1}}};
    end
    return {1'b0, sum[CNT_WIDTH-1:0]};
  endfunction

  always_comb begin
    if (remaining >= CNT_WIDTH'(LANES)) begin
      lanes = PW'(LANES);
    end else begin
      lanes = remaining[PW-1:0];
    end
  end

  nz_lane_popcount #(
    .LANES      (LANES),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_popcount (
    .act_dat (act_dat),
    .lanes   (lanes),
    .count   (pop)
  );

  assign sat_sum  = sat_add(acc, pop);
  assign rem_next = remaining - CNT_WIDTH'(lanes);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      acc       <= '0;
      shape_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (layer_vld) begin
            shape_q   <= layer_shape;
            remaining <= layer_shape;
            acc       <= '0;
            ovf_q     <= 1'b0;
            state     <= (layer_shape == '0) ? DONE : COUNT;
          end
        end
        COUNT: begin
          if (act_vld) begin
            acc       <= sat_sum[CNT_WIDTH-1:0];
            remaining <= rem_next;
            if (sat_sum[CNT_WIDTH]) begin
              ovf_q <= 1'b1;
            end
            if (rem_next == '0) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (nz_rdy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign layer_rdy = (state == IDLE);
  assign act_rdy   = (state == COUNT);
  assign nz_vld    = (state == DONE);
  assign nz_dat    = acc;
  assign shape_dat = shape_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_nz_count_monitor.sv
// Scoreboard bench for nz_count_monitor: a 16-bit and a 4-bit counter instance
// share stimulus; expected results come from an element-wise reference count.
module tb_nz_count_monitor;

  localparam int DW  = 16;
  localparam int LN  = 4;
  localparam int CW  = 16;
  localparam int CWN = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              layer_vld;
  logic [CW-1:0]     layer_shape;
  logic              act_vld;
  logic [LN*DW-1:0]  act_dat;
  logic              nz_rdy;

  logic              layer_rdy, act_rdy, nz_vld, overflow;
  logic [CW-1:0]     nz_dat, shape_dat;
  logic              layer_rdy_n, act_rdy_n, nz_vld_n, overflow_n;
  logic [CWN-1:0]    nz_dat_n, shape_dat_n;

  nz_count_monitor #(.DATA_WIDTH(DW), .LANES(LN), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .layer_vld(layer_vld), .layer_shape(layer_shape),
    .layer_rdy(layer_rdy), .act_vld(act_vld), .act_dat(act_dat), .act_rdy(act_rdy),
    .nz_vld(nz_vld), .nz_dat(nz_dat), .shape_dat(shape_dat), .nz_rdy(nz_rdy),
    .overflow(overflow)
  );

  nz_count_monitor #(.DATA_WIDTH(DW), .LANES(LN), .CNT_WIDTH(CWN)) dut_n (
    .clk(clk), .reset(reset), .layer_vld(layer_vld), .layer_shape(layer_shape[CWN-1:0]),
    .layer_rdy(layer_rdy_n), .act_vld(act_vld), .act_dat(act_dat), .act_rdy(act_rdy_n),
    .nz_vld(nz_vld_n), .nz_dat(nz_dat_n), .shape_dat(shape_dat_n), .nz_rdy(nz_rdy),
    .overflow(overflow_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int shape;
    int nz;
  } exp_t;

  int               total = 0;
  int               bad   = 0;
  exp_t             exp_q[$];
  exp_t             exp_qn[$];
  bit               chk_n = 1'b1;
  int               rdy_mode = 0;
  logic [LN*DW-1:0] cur_beats[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: element k of the layer is lane k%LN of beat k/LN.
  function automatic int model_nz(input int shape);
    int               n;
    logic [LN*DW-1:0] b;
    n = 0;
    for (int k = 0; k < shape; k++) begin
      b = cur_beats[k / LN];
      if (b[(k % LN)*DW +: DW] != '0) n++;
    end
    return n;
  endfunction

  function automatic logic [LN*DW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {DW'(l3), DW'(l2), DW'(l1), DW'(l0)};
  endfunction

  task automatic gen_random(input int shape);
    logic [LN*DW-1:0] b;
    int               nb;
    cur_beats.delete();
    nb = (shape + LN - 1) / LN;
    for (int i = 0; i < nb; i++) begin
      for (int l = 0; l < LN; l++) begin
        if (i*LN + l >= shape) b[l*DW +: DW] = DW'($urandom_range(1, 65535));
        else if ($urandom_range(0, 1) == 0) b[l*DW +: DW] = '0;
        else b[l*DW +: DW] = DW'($urandom);
      end
      cur_beats.push_back(b);
    end
  endtask

  task automatic wait_sig(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ((which == 0 && layer_rdy) || (which == 1 && act_rdy)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check(which == 0 ? "timeout_layer_rdy" : "timeout_act_rdy", 0, 1);
  endtask

  // exp_nz < 0 selects the reference model; otherwise the given constant.
  task automatic run_layer(input int shape, input int exp_nz, input int gap_max);
    exp_t e;
    bit   ok;
    e.shape = shape;
    e.nz    = (exp_nz < 0) ? model_nz(shape) : exp_nz;
    act_vld = 1'($urandom_range(0, 1));
    act_dat = {$urandom, $urandom};
    wait_sig(0, ok);
    if (!ok) return;
    exp_q.push_back(e);
    if (chk_n) exp_qn.push_back(e);
    layer_vld   = 1'b1;
    layer_shape = CW'(shape);
    @(posedge clk); #1;
    layer_vld   = 1'b0;
    act_vld     = 1'b0;
    layer_shape = CW'($urandom);
    if (shape == 0) begin
      @(negedge clk);
      check("zero_shape_nz_vld", nz_vld, 1);
      check("zero_shape_act_rdy", act_rdy, 0);
      return;
    end
    for (int b = 0; b < cur_beats.size(); b++) begin
      repeat ($urandom_range(0, gap_max)) begin
        act_vld   = 1'b0;
        act_dat   = {$urandom, $urandom};
        layer_vld = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      wait_sig(1, ok);
      if (!ok) return;
      act_vld = 1'b1;
      act_dat = cur_beats[b];
      @(posedge clk); #1;
      act_vld   = 1'b0;
      layer_vld = 1'b0;
      act_dat   = {$urandom, $urandom};
    end
    @(negedge clk);
    check("last_beat_nz_vld", nz_vld, 1);
    check("done_act_rdy", act_rdy, 0);
    check("done_layer_rdy", layer_rdy, 0);
  endtask

  task automatic drain();
    rdy_mode = 2;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || exp_qn.size() != 0); i++) @(negedge clk);
    check("drain_main", exp_q.size(), 0);
    check("drain_narrow", exp_qn.size(), 0);
  endtask

  initial begin
    nz_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       nz_rdy = ($urandom_range(0, 2) != 0);
        1:       nz_rdy = 1'b0;
        default: nz_rdy = 1'b1;
      endcase
    end
  end

  // Main instance monitor: pops on every consumed result, checks hold otherwise.
  bit            held = 1'b0;
  logic [CW-1:0] held_dat, held_shape;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_nz_vld", nz_vld, 1);
        check("hold_nz_dat", nz_dat, held_dat);
        check("hold_shape_dat", shape_dat, held_shape);
      end
      held = 1'b0;
      if (nz_vld && nz_rdy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result: got nz_dat=%0d with no layer pending", nz_dat);
        end else begin
          e = exp_q.pop_front();
          check("nz_dat", nz_dat, e.nz);
          check("shape_dat", shape_dat, e.shape);
          check("overflow", overflow, 0);
        end
      end else if (nz_vld) begin
        held       = 1'b1;
        held_dat   = nz_dat;
        held_shape = shape_dat;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && chk_n && nz_vld_n && nz_rdy) begin
      total++;
      if (exp_qn.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result_narrow: got nz_dat=%0d with no layer pending", nz_dat_n);
      end else begin
        e = exp_qn.pop_front();
        check("narrow_nz_dat", nz_dat_n, e.nz);
        check("narrow_shape_dat", shape_dat_n, e.shape);
        check("narrow_overflow", overflow_n, 0);
      end
    end
  end

  initial begin
    bit ok;
    reset = 1'b1; layer_vld = 1'b0; layer_shape = '0; act_vld = 1'b0; act_dat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_layer_rdy", layer_rdy, 1);
    check("reset_act_rdy", act_rdy, 0);
    check("reset_nz_vld", nz_vld, 0);
    check("reset_nz_dat", nz_dat, 0);
    check("reset_shape_dat", shape_dat, 0);
    check("reset_overflow", overflow, 0);
    reset = 1'b0;

    rdy_mode = 2;
    cur_beats = '{pack4(0, 5, 0, 7), pack4(1, 2, 3, 0)};
    run_layer(8, 5, 1);
    cur_beats = '{pack4(1, 1, 1, 1), pack4(1, 1, 9, 9)};
    run_layer(6, 6, 1);
    cur_beats.delete();
    run_layer(0, 0, 0);

    rdy_mode = 1;
    gen_random(8);
    run_layer(8, -1, 1);
    repeat (5) begin
      @(negedge clk);
      check("bp_nz_vld", nz_vld, 1);
      check("bp_layer_rdy", layer_rdy, 0);
      check("bp_act_rdy", act_rdy, 0);
    end
    rdy_mode = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp_rearm_layer_rdy", layer_rdy, 1);
    check("bp_released_nz_vld", nz_vld, 0);

    cur_beats = '{{LN*DW{1'b1}}, {LN*DW{1'b1}}, {LN*DW{1'b1}}, {LN*DW{1'b1}}};
    run_layer(15, 15, 0);
    drain();

    wait_sig(0, ok);
    layer_vld = 1'b1; layer_shape = 16'd8;
    @(posedge clk); #1;
    layer_vld = 1'b0;
    act_vld = 1'b1; act_dat = {LN*DW{1'b1}};
    @(posedge clk); #1;
    act_vld = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_layer_rdy", layer_rdy, 1);
    check("midreset_act_rdy", act_rdy, 0);
    check("midreset_shape_dat", shape_dat, 0);
    check("midreset_nz_dat", nz_dat, 0);
    repeat (3) begin
      @(negedge clk);
      check("midreset_no_result", nz_vld, 0);
    end
    cur_beats = '{pack4(3, 0, 0, 4), pack4(0, 0, 0, 0)};
    run_layer(8, 2, 0);

    rdy_mode = 0;
    for (int i = 0; i < 40; i++) begin
      int s;
      s = $urandom_range(0, 15);
      gen_random(s);
      run_layer(s, -1, 2);
    end
    drain();

    chk_n = 1'b0;
    rdy_mode = 0;
    for (int i = 0; i < 12; i++) begin
      int s;
      s = $urandom_range(16, 120);
      gen_random(s);
      run_layer(s, -1, 1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
